// File: rtl/csr_regfile_if.sv
// CSR access bus between the execute stage (master) and the machine-mode CSR file (slave).
interface csr_regfile_if #(
  parameter int WIDTH = 32
);
  logic [11:0]      csr_raddr;
  logic             csr_re;
  logic [WIDTH-1:0] csr_rdata;
  logic             csr_we;
  logic [11:0]      csr_waddr;
  logic [WIDTH-1:0] csr_wdata;
  logic             csr_illegal;

  modport master (
    output csr_raddr, csr_re, csr_we, csr_waddr, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_raddr, csr_re, csr_we, csr_waddr, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: trap CSRs, interrupt enable/pending, 64-bit cycle and retire counters.
module csr_regfile #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  csr_regfile_if.slave     bus,
  input  logic             inst_retire,
  input  logic             irq_sw,
  input  logic             irq_timer,
  input  logic             irq_external,
  input  logic             mstatus_mie_set,
  input  logic             mstatus_mie_clear,
  input  logic             mepc_update,
  input  logic [WIDTH-1:0] mepc_in,
  input  logic             mtval_update,
  input  logic [WIDTH-1:0] mtval_in,
  input  logic             mcause_update,
  input  logic             trap_type,
  input  logic [3:0]       mcause_in,
  output logic             mstatus_mie,
  output logic             mie_sw,
  output logic             mie_timer,
  output logic             mie_external,
  output logic             mip_sw,
  output logic             mip_timer,
  output logic             mip_external,
  output logic [WIDTH-1:0] mtvec,
  output logic [WIDTH-1:0] epc
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL = 32'h4000_1100;

  // Exception return addresses are always word aligned.
  function automatic logic [31:0] align_epc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mask_mtvec(input logic [31:0] v);
    return {v[31:2], 1'b0, v[0]};
  endfunction

  logic        r_mie;
  logic        r_mpie;
  logic        r_mie_sw;
  logic        r_mie_tim;
  logic        r_mie_ext;
  logic        r_mip_sw;
  logic        r_mip_tim;
  logic        r_mip_ext;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic        r_mcause_int;
  logic [3:0]  r_mcause_code;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [31:0] w_rdata;
  logic        w_r_impl;
  logic        w_w_impl;
  logic        w_w_ro;
  logic        w_unused;

  logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch, w_wr_mepc;
  logic w_wr_mcause, w_wr_mtval, w_wr_mcycle, w_wr_mcycleh;
  logic w_wr_minstret, w_wr_minstreth;

  assign w_unused = ^mepc_in[1:0];

  assign w_wr_mstatus   = bus.csr_we && (bus.csr_waddr == A_MSTATUS);
  assign w_wr_mie       = bus.csr_we && (bus.csr_waddr == A_MIE);
  assign w_wr_mtvec     = bus.csr_we && (bus.csr_waddr == A_MTVEC);
  assign w_wr_mscratch  = bus.csr_we && (bus.csr_waddr == A_MSCRATCH);
  assign w_wr_mepc      = bus.csr_we && (bus.csr_waddr == A_MEPC);
  assign w_wr_mcause    = bus.csr_we && (bus.csr_waddr == A_MCAUSE);
  assign w_wr_mtval     = bus.csr_we && (bus.csr_waddr == A_MTVAL);
  assign w_wr_mcycle    = bus.csr_we && (bus.csr_waddr == A_MCYCLE);
  assign w_wr_mcycleh   = bus.csr_we && (bus.csr_waddr == A_MCYCLEH);
  assign w_wr_minstret  = bus.csr_we && (bus.csr_waddr == A_MINSTRET);
  assign w_wr_minstreth = bus.csr_we && (bus.csr_waddr == A_MINSTRETH);

  always_comb begin
    w_rdata  = 32'h0;
    w_r_impl = 1'b1;
    case (bus.csr_raddr)
      A_MSTATUS:   w_rdata = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
      A_MISA:      w_rdata = MISA_VAL;
      A_MIE:       w_rdata = {20'b0, r_mie_ext, 3'b0, r_mie_tim, 3'b0, r_mie_sw, 3'b0};
      A_MTVEC:     w_rdata = r_mtvec;
      A_MSCRATCH:  w_rdata = r_mscratch;
      A_MEPC:      w_rdata = r_mepc;
      A_MCAUSE:    w_rdata = {r_mcause_int, 27'b0, r_mcause_code};
      A_MTVAL:     w_rdata = r_mtval;
      A_MIP:       w_rdata = {20'b0, r_mip_ext, 3'b0, r_mip_tim, 3'b0, r_mip_sw, 3'b0};
      A_MCYCLE:    w_rdata = r_mcycle[31:0];
      A_MINSTRET:  w_rdata = r_minstret[31:0];
      A_MCYCLEH:   w_rdata = r_mcycle[63:32];
      A_MINSTRETH: w_rdata = r_minstret[63:32];
      A_MHARTID:   w_rdata = 32'h0;
      default:     w_r_impl = 1'b0;
    endcase
  end

  always_comb begin
    w_w_impl = 1'b1;
    w_w_ro   = 1'b0;
    case (bus.csr_waddr)
      A_MISA, A_MHARTID, A_MIP: w_w_ro = 1'b1;
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
      A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH: w_w_impl = 1'b1;
      default: w_w_impl = 1'b0;
    endcase
  end

  assign bus.csr_rdata   = w_rdata;
  assign bus.csr_illegal = (bus.csr_re && !w_r_impl) ||
                           (bus.csr_we && (!w_w_impl || w_w_ro));

  // Trap-controller requests outrank software writes; clear outranks set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (mstatus_mie_clear) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (mstatus_mie_set) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mie  <= bus.csr_wdata[3];
      r_mpie <= bus.csr_wdata[7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie_sw   <= 1'b0;
      r_mie_tim  <= 1'b0;
      r_mie_ext  <= 1'b0;
      r_mip_sw   <= 1'b0;
      r_mip_tim  <= 1'b0;
      r_mip_ext  <= 1'b0;
      r_mtvec    <= mask_mtvec(MTVEC_RESET);
      r_mscratch <= 32'h0;
    end else begin
      r_mip_sw  <= irq_sw;
      r_mip_tim <= irq_timer;
      r_mip_ext <= irq_external;
      if (w_wr_mie) begin
        r_mie_sw  <= bus.csr_wdata[3];
        r_mie_tim <= bus.csr_wdata[7];
        r_mie_ext <= bus.csr_wdata[11];
      end
      if (w_wr_mtvec)    r_mtvec    <= mask_mtvec(bus.csr_wdata);
      if (w_wr_mscratch) r_mscratch <= bus.csr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mepc        <= 32'h0;
      r_mcause_int  <= 1'b0;
      r_mcause_code <= 4'h0;
      r_mtval       <= 32'h0;
    end else begin
      if (mepc_update)    r_mepc <= align_epc(mepc_in);
      else if (w_wr_mepc) r_mepc <= align_epc(bus.csr_wdata);
      if (mcause_update) begin
        r_mcause_int  <= trap_type;
        r_mcause_code <= mcause_in;
      end else if (w_wr_mcause) begin
        r_mcause_int  <= bus.csr_wdata[31];
        r_mcause_code <= bus.csr_wdata[3:0];
      end
      if (mtval_update)    r_mtval <= mtval_in;
      else if (w_wr_mtval) r_mtval <= bus.csr_wdata;
    end
  end

  // A software write to either half freezes the counter for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcycle <= 64'h0;
    end else if (w_wr_mcycle) begin
      r_mcycle[31:0] <= bus.csr_wdata;
    end else if (w_wr_mcycleh) begin
      r_mcycle[63:32] <= bus.csr_wdata;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_minstret <= 64'h0;
    end else if (w_wr_minstret) begin
      r_minstret[31:0] <= bus.csr_wdata;
    end else if (w_wr_minstreth) begin
      r_minstret[63:32] <= bus.csr_wdata;
    end else if (inst_retire) begin
      r_minstret <= r_minstret + 64'd1;
    end
  end

  assign mstatus_mie  = r_mie;
  assign mie_sw       = r_mie_sw;
  assign mie_timer    = r_mie_tim;
  assign mie_external = r_mie_ext;
  assign mip_sw       = r_mip_sw;
  assign mip_timer    = r_mip_tim;
  assign mip_external = r_mip_ext;
  assign mtvec        = r_mtvec;
  assign epc          = r_mepc;

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the datapath width; only 32 is supported.
REQ-002 Parameter MTVEC_RESET, default 32'h0000_0000, SHALL set the reset value of mtvec.
REQ-003 Ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- csr_raddr  in  12  CSR read address.
- csr_re  in  1  read strobe; only qualifies csr_illegal.
- csr_rdata  out  WIDTH  combinational read data.
- csr_we  in  1  software write strobe.
- csr_waddr  in  12  write address.
- csr_wdata  in  WIDTH  full new value, already computed by EX for RW/RS/RC.
- csr_illegal  out  1  combinational flag for an access to an unimplemented CSR, or a write to a read-only CSR.
- inst_retire  in  1  one instruction retired this cycle.
- irq_sw, irq_timer, irq_external  in  1 each  raw level interrupt lines.
- mstatus_mie_set  in  1  trap return (mret) from trap controller.
- mstatus_mie_clear  in  1  trap entry from trap controller.
- mepc_update  in  1  latch mepc_in.
- mepc_in  in  WIDTH  trapped PC.
- mtval_update  in  1  latch mtval_in.
- mtval_in  in  WIDTH  trap value.
- mcause_update  in  1  latch trap_type and mcause_in.
- trap_type  in  1  1 for interrupt, 0 for exception.
- mcause_in  in  4  exception code.
- mstatus_mie  out  1  mstatus.MIE.
- mie_sw, mie_timer, mie_external  out  1 each  mie bits 3, 7 and 11.
- mip_sw, mip_timer, mip_external  out  1 each  mip bits 3, 7 and 11.
- mtvec  out  WIDTH  mtvec register.
- epc  out  WIDTH  mepc register.

Function
REQ-004 The address map SHALL be: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14.
REQ-005 For any other address, csr_rdata SHALL read 0 and csr_illegal SHALL equal (csr_re|csr_we).
REQ-006 The read-only CSRs SHALL be misa (32'h4000_1100), mhartid (0) and mip.
- A write to any of them SHALL be ignored, and csr_illegal SHALL be 1.
REQ-007 mstatus field behaviour:
- Only MIE (bit 3) and MPIE (bit 7) are writable.
- MPP (bits 12:11) SHALL read 2'b11.
- All other bits SHALL read 0.
REQ-008 mie SHALL implement only bits 3, 7 and 11; other bits SHALL read 0.
REQ-009 mip bits 3, 7 and 11 SHALL be registered copies of irq_sw, irq_timer and irq_external, giving exactly 1 cycle of latency.
REQ-010 mepc bits 1:0 SHALL always read 0, whether written by software or by mepc_in.
- mtvec bit 1 SHALL read 0.
REQ-011 mcause SHALL read {trap_type, 27'b0, code[3:0]}.
- Software writes SHALL store bit 31 and bits 3:0 only.
REQ-012 Reads SHALL return the current register value with no write bypass; a write becomes visible on csr_rdata the next cycle.
REQ-013 When mstatus_mie_clear is asserted: MPIE <= MIE, MIE <= 0.
REQ-014 When mstatus_mie_set is asserted: MIE <= MPIE, MPIE <= 1.
REQ-015 If mstatus_mie_set and mstatus_mie_clear are asserted together, clear SHALL win.
REQ-016 Trap-controller updates SHALL take priority over a same-cycle software write to the same CSR (mstatus, mepc, mcause, mtval); the software write is dropped.
REQ-017 mcycle behaviour:
- 64-bit counter {mcycleh, mcycle}.
- Increments by 1 every cycle when not in reset.
- Wraps from all-ones to 0.
REQ-018 minstret behaviour:
- 64-bit counter {minstreth, minstret}.
- Increments by 1 when inst_retire=1.
- Wraps from all-ones to 0.
REQ-019 A software write to a counter half SHALL replace that half with csr_wdata.
- The other half SHALL hold.
- The counter SHALL NOT increment in that cycle, so no carry is propagated.
REQ-020 The low-to-high carry SHALL occur in the same cycle the low half wraps.
REQ-021 All output ports to the trap controller SHALL be direct register outputs, with no combinational path from inputs.

Reset
REQ-022 When rst=1 at a clock edge, the following SHALL hold the next cycle:
- mstatus MIE=0 and MPIE=0.
- mie=0, mip=0, mscratch=0, mepc=0, mcause=0, mtval=0.
- mtvec=MTVEC_RESET.
- All counters=0.
REQ-023 Reset SHALL override every same-cycle write, trap update and increment.
REQ-024 After rst is released, mcycle SHALL read 1 one cycle later.

Verification
REQ-025 Scenario: after reset, read 0x301, 0x300 and 0xB00 in consecutive cycles.
- Required: 32'h4000_1100, then 32'h0000_1800, then a small nonzero count.
REQ-026 Scenario: write mstatus=0x8, then pulse mstatus_mie_clear, then pulse mstatus_mie_set.
- Required: mstatus reads 0x1808, then 0x1880, then 0x1888.
REQ-027 Scenario: in one cycle, csr_we to 0x341 with 0x1234 and mepc_update with mepc_in=0x0000_2007.
- Required: epc=0x0000_2004.
REQ-028 Scenario: set mcycle=0xFFFF_FFFF and mcycleh=0.
- Required: two cycles later mcycleh=1 and mcycle=0x0000_0000.
REQ-029 Scenario: raise irq_timer at cycle N, and write 0x344 with 0xFFFF_FFFF.
- Required: mip_timer=1 from cycle N+1; the write is ignored; csr_illegal=1.
REQ-030 Scenario: assert rst during a csr_we to mtvec with MTVEC_RESET=0x100.
- Required: mtvec=0x100 and all counters=0.
